instr_cache_refill: RTL and testbench



---
 rtl/instr_cache_refill_pkg.sv | 16 +
 rtl/instr_cache_refill_if.sv | 33 +++
 rtl/instr_cache_refill_line_buffer.sv | 31 +++
 rtl/instr_cache_refill.sv | 102 ++++++++++
 tb/tb_instr_cache_refill.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_cache_refill_pkg.sv
// Shared constants, state encoding and address helper for the instruction-cache refill slice.
package instr_cache_pkg;
   localparam int WORD_SIZE      = 32;
   localparam int BLOCK_WIDTH    = 256;
   localparam int ADDR_WIDTH     = 32;
   localparam int WORD_COUNT     = BLOCK_WIDTH / WORD_SIZE;
   localparam int WORD_OFFSET_W  = $clog2(WORD_COUNT);
   localparam int BYTE_OFFSET_W  = $clog2(WORD_SIZE / 8);
   localparam int BLOCK_OFFSET_W = WORD_OFFSET_W + BYTE_OFFSET_W;

   typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} t_refill_state;

   function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
      return {addr[ADDR_WIDTH-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
   endfunction
endpackage

// File: rtl/instr_cache_refill_if.sv
// Fetch, memory-bus and cache-write signals of the refill engine, named from the engine's side.
interface instr_cache_refill_if;
   import instr_cache_pkg::*;

   logic                   i_miss;
   logic [ADDR_WIDTH-1:0]  i_miss_addr;
   logic                   o_stall;
   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
   // a request holds valid and o_mem_addr stable until accepted, beats may arrive with gaps.
   logic                   o_mem_req_valid;
   logic                   i_mem_req_ready;
   logic [ADDR_WIDTH-1:0]  o_mem_addr;
   logic                   i_mem_rsp_valid;
   logic [WORD_SIZE-1:0]   i_mem_rsp_data;
   logic                   i_mem_rsp_err;
   logic                   o_mem_rsp_ready;
   logic                   o_cache_we;
   logic [ADDR_WIDTH-1:0]  o_cache_addr;
   logic [BLOCK_WIDTH-1:0] o_cache_block;
   logic                   o_bus_err;

   modport master (
      input  i_miss, i_miss_addr, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err,
      output o_stall, o_mem_req_valid, o_mem_addr, o_mem_rsp_ready, o_cache_we, o_cache_addr,
             o_cache_block, o_bus_err
   );

   modport slave (
      output i_miss, i_miss_addr, i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err,
      input  o_stall, o_mem_req_valid, o_mem_addr, o_mem_rsp_ready, o_cache_we, o_cache_addr,
             o_cache_block, o_bus_err
   );
endinterface

// File: rtl/instr_cache_refill_line_buffer.sv
// Beat counter plus word-indexed line register; beat k lands in word k of the line.
module refill_line_buffer
   import instr_cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   clear,
   input  logic                   load,
   input  logic [WORD_SIZE-1:0]   data,
   output logic [BLOCK_WIDTH-1:0] line,
   output logic                   last
);
   logic [WORD_OFFSET_W-1:0] count;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         count <= '0;
         line  <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         // The counter wraps to 0 naturally on the final beat.
         count <= count + 1'b1;
         for (int k = 0; k < WORD_COUNT; k++) begin
            if (count == WORD_OFFSET_W'(k)) line[k*WORD_SIZE +: WORD_SIZE] <= data;
         end
      end
   end

   assign last = (count == WORD_OFFSET_W'(WORD_COUNT - 1));
endmodule

// File: rtl/instr_cache_refill.sv
// Cache-miss refill engine: one block-aligned burst read, 8 beats assembled, one-cycle line write.
module instr_cache_refill
   import instr_cache_pkg::*;
(
   input  logic                 clk,
   input  logic                 arst,
   instr_cache_refill_if.master bus,
   output t_refill_state        state_dbg
);
   t_refill_state          state;
   logic [ADDR_WIDTH-1:0]  base_q;
   logic                   err_q;
   logic                   stall_q, req_valid_q, rsp_ready_q, we_q, bus_err_q;
   logic [ADDR_WIDTH-1:0]  cache_addr_q;
   logic [BLOCK_WIDTH-1:0] cache_block_q;

   logic                   buf_clear, buf_load, buf_last;
   logic [BLOCK_WIDTH-1:0] buf_line;

   assign buf_clear = (state == IDLE) && bus.i_miss;
   assign buf_load  = (state == RECV) && rsp_ready_q && bus.i_mem_rsp_valid;

   refill_line_buffer u_line_buffer (
      .clk   (clk),
      .arst  (arst),
      .clear (buf_clear),
      .load  (buf_load),
      .data  (bus.i_mem_rsp_data),
      .line  (buf_line),
      .last  (buf_last)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state         <= IDLE;
         base_q        <= '0;
         err_q         <= 1'b0;
         stall_q       <= 1'b0;
         req_valid_q   <= 1'b0;
         rsp_ready_q   <= 1'b0;
         we_q          <= 1'b0;
         bus_err_q     <= 1'b0;
         cache_addr_q  <= '0;
         cache_block_q <= '0;
      end else begin
         we_q      <= 1'b0;
         bus_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_miss) begin
                  base_q      <= block_base(bus.i_miss_addr);
                  err_q       <= 1'b0;
                  stall_q     <= 1'b1;
                  req_valid_q <= 1'b1;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (bus.i_mem_req_ready) begin
                  req_valid_q <= 1'b0;
                  rsp_ready_q <= 1'b1;
                  state       <= RECV;
               end
            end
            RECV: begin
               if (bus.i_mem_rsp_valid) begin
                  if (bus.i_mem_rsp_err) err_q <= 1'b1;
                  if (buf_last) begin
                     rsp_ready_q <= 1'b0;
                     if (err_q || bus.i_mem_rsp_err) begin
                        bus_err_q <= 1'b1;
                        stall_q   <= 1'b0;
                        state     <= IDLE;
                     end else begin
                        // The last beat is the top word; merge it here so the line is complete in WRITE.
                        we_q          <= 1'b1;
                        cache_addr_q  <= base_q;
                        cache_block_q <= {bus.i_mem_rsp_data, buf_line[BLOCK_WIDTH-WORD_SIZE-1:0]};
                        state         <= WRITE;
                     end
                  end
               end
            end
            WRITE: begin
               stall_q <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_stall         = stall_q;
   assign bus.o_mem_req_valid = req_valid_q;
   assign bus.o_mem_addr      = base_q;
   assign bus.o_mem_rsp_ready = rsp_ready_q;
   assign bus.o_cache_we      = we_q;
   assign bus.o_cache_addr    = cache_addr_q;
   assign bus.o_cache_block   = cache_block_q;
   assign bus.o_bus_err       = bus_err_q;
   assign state_dbg           = state;
endmodule

// File: tb/tb_instr_cache_refill.sv
// Directed bench for instr_cache_refill: normal refill, request backpressure, beat gaps,
// bus error, mid-refill reset and ignored misses.
module tb_instr_cache_refill;
   import instr_cache_pkg::*;

   logic          clk;
   logic          arst;
   t_refill_state state_dbg;

   instr_cache_refill_if bus ();

   instr_cache_refill dut (
      .clk       (clk),
      .arst      (arst),
      .bus       (bus.master),
      .state_dbg (state_dbg)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   logic [WORD_SIZE-1:0] exp_q[$];
   int req_hs_cnt = 0;
   int beat_cnt   = 0;
   int we_cnt     = 0;
   int err_cnt    = 0;

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
      $fatal(1);
   end

   // bus event monitor
   always @(posedge clk) begin
      if (!arst) begin
         if (bus.o_mem_req_valid && bus.i_mem_req_ready) req_hs_cnt++;
         if (bus.o_mem_rsp_ready && bus.i_mem_rsp_valid) beat_cnt++;
         if (bus.o_cache_we) we_cnt++;
         if (bus.o_bus_err) err_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_blk(input string tag, input logic [BLOCK_WIDTH-1:0] obs,
                            input logic [BLOCK_WIDTH-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: the line expected on the write strobe is built from the queued beat words.
   task automatic check_line(input string tag, input logic [31:0] exp_addr);
      logic [BLOCK_WIDTH-1:0] exp_blk;
      exp_blk = '0;
      for (int k = 0; k < WORD_COUNT; k++) begin
         if (exp_q.size() > 0) exp_blk[k*WORD_SIZE +: WORD_SIZE] = exp_q.pop_front();
      end
      check({tag, "_we"}, 32'(bus.o_cache_we), 32'd1);
      check({tag, "_addr"}, bus.o_cache_addr, exp_addr);
      check_blk({tag, "_block"}, bus.o_cache_block, exp_blk);
   endtask

   // Driver: present a miss, hold request ready low for 'hold' cycles, then complete the handshake.
   task automatic start_refill(input string tag, input logic [31:0] addr, input int hold);
      logic [31:0] exp_base;
      int          beats_before;
      exp_base = {addr[31:5], 5'b0};
      bus.i_miss          = 1'b1;
      bus.i_miss_addr     = addr;
      bus.i_mem_req_ready = 1'b0;
      tick();
      bus.i_miss = 1'b0;
      check({tag, "_req_valid"}, 32'(bus.o_mem_req_valid), 32'd1);
      check({tag, "_mem_addr"}, bus.o_mem_addr, exp_base);
      check({tag, "_stall"}, 32'(bus.o_stall), 32'd1);
      beats_before = beat_cnt;
      bus.i_mem_rsp_valid = (hold > 0);
      bus.i_mem_rsp_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_valid"}, 32'(bus.o_mem_req_valid), 32'd1);
         check({tag, "_hold_addr"}, bus.o_mem_addr, exp_base);
         check({tag, "_hold_rsp_ready"}, 32'(bus.o_mem_rsp_ready), 32'd0);
      end
      bus.i_mem_rsp_valid = 1'b0;
      if (hold > 0) check({tag, "_no_early_beats"}, beat_cnt, beats_before);
      bus.i_mem_req_ready = 1'b1;
      tick();
      bus.i_mem_req_ready = 1'b0;
      check({tag, "_rsp_ready"}, 32'(bus.o_mem_rsp_ready), 32'd1);
      check({tag, "_req_dropped"}, 32'(bus.o_mem_req_valid), 32'd0);
   endtask

   // Driver: deliver beats first..last-1 with word0+k data, optional gaps, error beat and miss noise.
   task automatic send_beats(input string tag, input logic [31:0] word0, input int first,
                             input int last, input int gaps[8], input int err_beat,
                             input logic noise_miss);
      for (int k = first; k < last; k++) begin
         for (int g = 0; g < gaps[k]; g++) begin
            bus.i_mem_rsp_valid = 1'b0;
            tick();
            check({tag, "_gap_we"}, 32'(bus.o_cache_we), 32'd0);
         end
         bus.i_mem_rsp_valid = 1'b1;
         bus.i_mem_rsp_data  = word0 + 32'(k);
         bus.i_mem_rsp_err   = (k == err_beat);
         if (noise_miss) begin
            bus.i_miss      = 1'b1;
            bus.i_miss_addr = 32'h0000_9990;
         end
         exp_q.push_back(word0 + 32'(k));
         tick();
         if (k < WORD_COUNT - 1) check({tag, "_early_we"}, 32'(bus.o_cache_we), 32'd0);
      end
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_mem_rsp_err   = 1'b0;
      bus.i_miss          = 1'b0;
   endtask

   int no_gaps[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
   int gap_tab[8]  = '{2, 0, 3, 1, 4, 0, 2, 1};

   initial begin
      arst                = 1'b1;
      bus.i_miss          = 1'b0;
      bus.i_miss_addr     = '0;
      bus.i_mem_req_ready = 1'b0;
      bus.i_mem_rsp_valid = 1'b0;
      bus.i_mem_rsp_data  = '0;
      bus.i_mem_rsp_err   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      arst = 1'b0;

      // reset state
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      check("rst_stall", 32'(bus.o_stall), 32'd0);
      check("rst_req_valid", 32'(bus.o_mem_req_valid), 32'd0);
      check("rst_mem_addr", bus.o_mem_addr, 32'd0);
      check("rst_rsp_ready", 32'(bus.o_mem_rsp_ready), 32'd0);
      check("rst_we", 32'(bus.o_cache_we), 32'd0);
      check("rst_bus_err", 32'(bus.o_bus_err), 32'd0);
      check_blk("rst_block", bus.o_cache_block, '0);

      // T1: straight refill, write strobe at cycle 10, idle at cycle 11
      start_refill("t1", 32'h0000_1234, 0);
      send_beats("t1", 32'h0000_00A0, 0, 8, no_gaps, -1, 1'b0);
      check_line("t1", 32'h0000_1220);
      check("t1_state_write", 32'(state_dbg), 32'(WRITE));
      tick();
      check("t1_we_off", 32'(bus.o_cache_we), 32'd0);
      check("t1_stall_off", 32'(bus.o_stall), 32'd0);
      check("t1_hold_addr", bus.o_cache_addr, 32'h0000_1220);
      check("t1_single_req", req_hs_cnt, 32'd1);

      // T2: request backpressure for 5 cycles
      start_refill("t2", 32'h0000_1234, 5);
      send_beats("t2", 32'h0000_00B0, 0, 8, no_gaps, -1, 1'b0);
      check_line("t2", 32'h0000_1220);
      tick();

      // T3: gaps between beats
      start_refill("t3", 32'h0000_2004, 0);
      send_beats("t3", 32'h0000_00C0, 0, 8, gap_tab, -1, 1'b0);
      check_line("t3", 32'h0000_2000);
      tick();
      check("t3_we_once", 32'(bus.o_cache_we), 32'd0);

      // T4: error on beat 3, burst drained, no write
      start_refill("t4", 32'h0000_3018, 0);
      send_beats("t4", 32'h0000_00D0, 0, 8, no_gaps, 3, 1'b0);
      exp_q.delete();
      check("t4_bus_err", 32'(bus.o_bus_err), 32'd1);
      check("t4_no_we", 32'(bus.o_cache_we), 32'd0);
      check("t4_stall", 32'(bus.o_stall), 32'd0);
      check("t4_state", 32'(state_dbg), 32'(IDLE));
      tick();
      check("t4_err_pulse", 32'(bus.o_bus_err), 32'd0);
      check("t4_beats_drained", beat_cnt, 32'd32);

      // T5: asynchronous reset while beat 4 is presented
      start_refill("t5", 32'h0000_5000, 0);
      send_beats("t5", 32'h0000_0050, 0, 4, no_gaps, -1, 1'b0);
      bus.i_mem_rsp_valid = 1'b1;
      bus.i_mem_rsp_data  = 32'h0000_0054;
      #2;
      arst = 1'b1;
      #1;
      check("t5_async_state", 32'(state_dbg), 32'(IDLE));
      check("t5_async_stall", 32'(bus.o_stall), 32'd0);
      check("t5_async_rsp_ready", 32'(bus.o_mem_rsp_ready), 32'd0);
      check("t5_async_mem_addr", bus.o_mem_addr, 32'd0);
      check_blk("t5_async_block", bus.o_cache_block, '0);
      bus.i_mem_rsp_valid = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      arst = 1'b0;
      start_refill("t5b", 32'h0000_0040, 0);
      send_beats("t5b", 32'h0000_00E0, 0, 8, no_gaps, -1, 1'b0);
      check_line("t5b", 32'h0000_0040);
      tick();

      // T6: misses during RECV are ignored
      start_refill("t6", 32'h0000_7010, 0);
      send_beats("t6", 32'h0000_00F0, 0, 8, no_gaps, -1, 1'b1);
      check_line("t6", 32'h0000_7000);
      tick();
      tick();
      check("t6_state_idle", 32'(state_dbg), 32'(IDLE));
      check("t6_no_extra_req", 32'(bus.o_mem_req_valid), 32'd0);

      // totals
      check("tot_requests", req_hs_cnt, 32'd7);
      check("tot_beats", beat_cnt, 32'd52);
      check("tot_writes", we_cnt, 32'd5);
      check("tot_bus_errs", err_cnt, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
